// File: rtl/onchip_mem_stream_master_pkg.sv
// Shared types and constants for the on-chip memory stream master.
package onchip_mem_stream_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/onchip_mem_stream_master_fifo.sv
// Read-return buffer: 32-bit synchronous FIFO with occupancy count.
module sync_fifo_w32 #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [31:0]   wdata_i,
    input  logic          pop_i,
    output logic [31:0]   rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/onchip_mem_stream_master.sv
// Avalon-MM master moving 32-bit words between streams and on-chip memory.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// WRITE | draining the sink stream into consecutive memory words
// READ  | issuing reads, throttled by outstanding + buffered words
// DRAIN | all reads issued, waiting for returns and the FIFO to empty
// DONE  | one-cycle completion pulse
module onchip_mem_stream_master
    import onchip_mem_stream_master_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 40000,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_len,
    output logic              busy,
    output logic              done,
    input  logic [31:0]       snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [31:0]       src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d, addr_next;
    logic [15:0]             rem_q, rem_d;
    logic [CW-1:0]           outst_q, outst_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             inflight;
    logic                    fifo_full, fifo_empty;
    logic                    wr_acc, rd_acc, rd_ret;

    assign avm_byteenable = BYTEEN_ALL;
    assign inflight       = {1'b0, outst_q} + {1'b0, fifo_count};
    assign rd_ret         = pipe_q[READ_LATENCY-1];
    assign addr_next      = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
    assign wr_acc         = avm_write & ~avm_waitrequest;
    assign rd_acc         = avm_read & ~avm_waitrequest;
    assign src_valid      = ~fifo_empty;

    // State, command counters, outstanding count and the read-latency token pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            outst_q <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            outst_q <= outst_d;
            pipe_q  <= pipe_d;
        end
    end

    // Bus strobes and next-state; write strobes follow the sink handshake directly.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rem_d          = rem_q;
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        snk_ready      = 1'b0;
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_chipselect = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len == 16'd0) begin
                        state_d = ST_DONE;
                    end else if (cmd_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                snk_ready      = ~avm_waitrequest & (rem_q != 16'd0);
                avm_write      = snk_valid & (rem_q != 16'd0);
                avm_chipselect = avm_write;
                avm_address    = addr_q;
                avm_writedata  = snk_data;
                if (wr_acc) begin
                    addr_d = addr_next;
                    rem_d  = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                // Reserving FIFO space per issued read keeps the buffer from overflowing.
                avm_read       = (rem_q != 16'd0) & ~fifo_full
                               & (inflight < (CW+1)'(FIFO_DEPTH));
                avm_chipselect = avm_read;
                avm_address    = addr_q;
                if (rd_acc) begin
                    addr_d = addr_next;
                    rem_d  = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (outst_q == '0 && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Token pipe mirrors the memory's fixed read latency; outstanding tracks its population.
    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = rd_acc;
        outst_d   = outst_q + CW'(rd_acc) - CW'(rd_ret);
    end

    sync_fifo_w32 #(
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (rd_ret),
        .wdata_i (avm_readdata),
        .pop_i   (src_valid & src_ready),
        .rdata_o (src_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
